gaus_window: RTL and testbench



---
 rtl/gaus_window.sv | 169 ++++++++++++++++
 tb/tb_gaus_window.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gaus_window.sv
`default_nettype none
// ============================================================================
//  Module   : gaus_window
//  Purpose  : Window builder in front of the 7x7 Gaussian convolution stage.
//             It takes a raster-order 8-bit pixel stream and keeps six line
//             buffers plus a 7x7 register window. It pulses `start` for every
//             accepted pixel whose 7x7 neighbourhood lies fully inside the
//             frame.
//  Ports    : clk        - system clock, rising edge
//             rst        - synchronous, active-low reset
//             sof        - start of frame, clears the x/y position
//             pix_in     - 8-bit input pixel
//             pix_val    - pix_in valid (one pixel per cycle, no backpressure)
//             col1..col7 - window rows, col1 = row y-6 ... col7 = row y;
//                          [55:48] = column x-6 ... [7:0] = column x
//             start      - one-cycle strobe, col1..col7 valid with it
//             frame_done - one-cycle pulse after the last pixel of a frame
//             cx, cy     - window-centre coordinate (x-3, y-3), valid with
//                          start; present only with GAUS_WINDOW_COORD_EN
//  Options  : `define GAUS_WINDOW_COORD_EN adds the cx/cy outputs
//  Revision : 1.0 - initial release
// ============================================================================
module gaus_window #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sof,
    input  logic [7:0]    pix_in,
    input  logic          pix_val,
    output logic [55:0]   col1,
    output logic [55:0]   col2,
    output logic [55:0]   col3,
    output logic [55:0]   col4,
    output logic [55:0]   col5,
    output logic [55:0]   col6,
    output logic [55:0]   col7,
    output logic          start,
    output logic          frame_done
`ifdef GAUS_WINDOW_COORD_EN
    ,
    output logic [XW-1:0] cx,
    output logic [YW-1:0] cy
`endif
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_MIN  = XW'(6);
    localparam logic [YW-1:0] Y_MIN  = YW'(6);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
`ifdef GAUS_WINDOW_COORD_EN
    localparam logic [XW-1:0] X_HALF = XW'(3);
    localparam logic [YW-1:0] Y_HALF = YW'(3);
`endif

    logic [XW-1:0] x;
    logic [YW-1:0] y;

    // A pixel that arrives together with sof belongs to position (0,0) of the
    // new frame, so all position-dependent logic uses the effective position.
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    logic          acc;
    logic          in_win;
    logic          at_end;

    assign acc    = rst & pix_val;
    assign ex     = sof ? '0 : x;
    assign ey     = sof ? '0 : y;
    assign in_win = (ex >= X_MIN) && (ey >= Y_MIN);
    // Frame completion looks at the old position: a last pixel that collides
    // with sof still closes the frame.
    assign at_end = (x == X_LAST) && (y == Y_LAST);

    // ------------------------------------------------------------------
    // Line buffers: lb[0] holds row y-1 ... lb[5] holds row y-6. They are
    // not reset; start is gated, so stale contents never reach a strobe.
    // ------------------------------------------------------------------
    logic [7:0] lb [0:5][0:IMG_W-1];

    always_ff @(posedge clk) begin
        if (acc) begin
            lb[0][ex] <= pix_in;
            for (int k = 1; k < 6; k++) begin
                lb[k][ex] <= lb[k-1][ex];
            end
        end
    end

    // Vertical column at the current x, oldest row first.
    logic [7:0] vcol [0:6];

    generate
        for (genvar r = 0; r < 6; r++) begin : g_vcol
            assign vcol[r] = lb[5-r][ex];
        end
    endgenerate
    assign vcol[6] = pix_in;

    // ------------------------------------------------------------------
    // 7x7 window: every row shifts one byte left and takes the new column
    // byte on the right.
    // ------------------------------------------------------------------
    logic [55:0] win [0:6];

    generate
        for (genvar r = 0; r < 7; r++) begin : g_row
            always_ff @(posedge clk) begin
                if (!rst) begin
                    win[r] <= '0;
                end else if (acc) begin
                    win[r] <= {win[r][47:0], vcol[r]};
                end
            end
        end
    endgenerate

    assign col1 = win[0];
    assign col2 = win[1];
    assign col3 = win[2];
    assign col4 = win[3];
    assign col5 = win[4];
    assign col6 = win[5];
    assign col7 = win[6];

    // ------------------------------------------------------------------
    // Position counters and strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            x          <= '0;
            y          <= '0;
            start      <= 1'b0;
            frame_done <= 1'b0;
`ifdef GAUS_WINDOW_COORD_EN
            cx         <= '0;
            cy         <= '0;
`endif
        end else begin
            start      <= acc && in_win;
            frame_done <= acc && at_end;
            if (acc) begin
                if (ex == X_LAST) begin
                    x <= '0;
                    y <= (ey == Y_LAST) ? '0 : ey + Y_ONE;
                end else begin
                    x <= ex + X_ONE;
                    y <= ey;
                end
            end else if (sof) begin
                x <= '0;
                y <= '0;
            end
`ifdef GAUS_WINDOW_COORD_EN
            if (acc && in_win) begin
                cx <= ex - X_HALF;
                cy <= ey - Y_HALF;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gaus_window.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gaus_window
//  Purpose  : Self-checking bench for gaus_window on an 8x8 frame. A
//             positional reference model stores every accepted pixel at its
//             (x,y) image position and builds the expected window directly
//             from that image.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gaus_window;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int XW = 3;
    localparam int YW = 3;

    logic        clk = 1'b0;
    logic        rst, sof, pix_val;
    logic [7:0]  pix_in;
    logic [55:0] col1, col2, col3, col4, col5, col6, col7;
    logic        start, frame_done;
`ifdef GAUS_WINDOW_COORD_EN
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
`endif

    always #5 clk = ~clk;

    gaus_window #(.IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW)) dut (
        .clk        (clk),
        .rst        (rst),
        .sof        (sof),
        .pix_in     (pix_in),
        .pix_val    (pix_val),
        .col1       (col1),
        .col2       (col2),
        .col3       (col3),
        .col4       (col4),
        .col5       (col5),
        .col6       (col6),
        .col7       (col7),
        .start      (start),
        .frame_done (frame_done)
`ifdef GAUS_WINDOW_COORD_EN
        ,
        .cx         (cx),
        .cy         (cy)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model state
    int          mx = 0, my = 0;
    logic [7:0]  img [H][W];
    logic [55:0] ew  [7];
    bit          win_known = 0;
    int          ecx = 0, ecy = 0;
    int          n_start = 0, n_fd = 0;
    logic [55:0] cap1_c1, cap1_c7, cap4_c1, cap4_c7;

    function automatic logic [55:0] obs(input int k);
        case (k)
            0: return col1;
            1: return col2;
            2: return col3;
            3: return col4;
            4: return col5;
            5: return col6;
            default: return col7;
        endcase
    endfunction

    task automatic step(input bit r, input bit s, input bit v, input logic [7:0] p);
        bit es, efd;
        rst = r; sof = s; pix_val = v; pix_in = p;
        @(posedge clk);
        #1;
        es = 0; efd = 0;
        if (!r) begin
            mx = 0; my = 0;
            for (int k = 0; k < 7; k++) ew[k] = '0;
            win_known = 1;
            ecx = 0; ecy = 0;
        end else if (v) begin
            efd = (mx == W-1) && (my == H-1);
            if (s) begin mx = 0; my = 0; end
            img[my][mx] = p;
            if (mx >= 6 && my >= 6) begin
                es = 1;
                for (int k = 0; k < 7; k++) begin
                    ew[k] = '0;
                    for (int j = 0; j < 7; j++)
                        ew[k] = {ew[k][47:0], img[my-6+k][mx-6+j]};
                end
                win_known = 1;
                ecx = mx - 3; ecy = my - 3;
            end else begin
                win_known = 0;
            end
            mx++;
            if (mx == W) begin
                mx = 0; my++;
                if (my == H) my = 0;
            end
        end else if (s) begin
            mx = 0; my = 0;
        end
        check("start", {63'd0, start}, {63'd0, es});
        check("frame_done", {63'd0, frame_done}, {63'd0, efd});
        if (win_known)
            for (int k = 0; k < 7; k++)
                check($sformatf("col%0d", k+1), {8'd0, obs(k)}, {8'd0, ew[k]});
`ifdef GAUS_WINDOW_COORD_EN
        if (es || !r) begin
            check("cx", {61'd0, cx}, 64'(ecx));
            check("cy", {61'd0, cy}, 64'(ecy));
        end
`endif
        if (start) begin
            if (n_start == 0) begin cap1_c1 = col1; cap1_c7 = col7; end
            if (n_start == 3) begin cap4_c1 = col1; cap4_c7 = col7; end
        end
        n_start += int'(start);
        n_fd    += int'(frame_done);
    endtask

    // mode 0: ramp (8*y+x), 1: constant 0xFF, 2: random
    task automatic drive_frame(input int mode, input bit toggle);
        logic [7:0] p;
        for (int i = 0; i < W*H; i++) begin
            p = (mode == 0) ? 8'(i) : (mode == 1) ? 8'hFF : 8'($urandom);
            step(1, i == 0, 1, p);
            if (toggle) step(1, 0, 0, 8'($urandom));
        end
        step(1, 0, 0, 8'h00);
    endtask

    task automatic partial(input int n);
        for (int i = 0; i < n; i++) step(1, i == 0, 1, 8'(i + 100));
    endtask

    initial begin
        step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'h55);

        // Plain ramp frame with known window constants
        n_start = 0; n_fd = 0;
        drive_frame(0, 0);
        check("ramp_starts", 64'(n_start), 64'd4);
        check("ramp_fd", 64'(n_fd), 64'd1);
        check("ramp_first_col1", {8'd0, cap1_c1}, {8'd0, 56'h00010203040506});
        check("ramp_first_col7", {8'd0, cap1_c7}, {8'd0, 56'h30313233343536});
        check("ramp_fourth_col1", {8'd0, cap4_c1}, {8'd0, 56'h090A0B0C0D0E0F});
        check("ramp_fourth_col7", {8'd0, cap4_c7}, {8'd0, 56'h393A3B3C3D3E3F});

        // Ramp with pix_val toggling
        n_start = 0; n_fd = 0;
        drive_frame(0, 1);
        check("toggle_starts", 64'(n_start), 64'd4);
        check("toggle_fd", 64'(n_fd), 64'd1);

        // Constant frame, then back-to-back ramp
        n_start = 0; n_fd = 0;
        drive_frame(1, 0);
        drive_frame(0, 0);
        check("ff_ramp_starts", 64'(n_start), 64'd8);
        check("ff_ramp_fd", 64'(n_fd), 64'd2);

        // Abort at (3,5) via sof, then a clean frame
        n_start = 0; n_fd = 0;
        partial(5*W + 3);
        drive_frame(0, 0);
        check("abort_starts", 64'(n_start), 64'd4);
        check("abort_fd", 64'(n_fd), 64'd1);

        // Reset at (2,6), then a clean frame
        n_start = 0; n_fd = 0;
        partial(6*W + 2);
        step(0, 0, 1, 8'h77);
        drive_frame(0, 0);
        check("reset_starts", 64'(n_start), 64'd4);
        check("reset_fd", 64'(n_fd), 64'd1);

        // sof colliding with the last pixel of a frame
        n_fd = 0;
        partial(W*H - 1);
        step(1, 1, 1, 8'h99);
        check("sof_last_fd", 64'(n_fd), 64'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++)
            step(($urandom % 500) != 0, ($urandom % 100) == 0,
                 ($urandom % 4) != 0, 8'($urandom));

        // Random full frame with ramp follow-up
        drive_frame(2, 0);
        drive_frame(0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
